// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup is purely combinational from the table state, so the
//   prediction for lookup_pc is available in the same cycle. Training is
//   applied at the rising clk edge and becomes visible to lookup on the
//   following cycle. There is no bypass from update to lookup.
//
//   Optional feature macro: BTB_STATS_EN adds the resolved-branch and
//   mispredict counters together with their output ports.
//
// Ports
//   clk                          rising-edge clock
//   reset_n                      asynchronous active-low reset
//   lookup_pc[31:0]              PC being fetched (bits [1:0] ignored)
//   branch_prediction_actual     predict taken for lookup_pc
//   pc_target_prediction_actual  predicted target, 0 when not predicting taken
//   update_valid                 a branch resolved this cycle
//   update_pc[31:0]              PC of the resolved branch (bits [1:0] ignored)
//   update_target[31:0]          computed target of the resolved branch
//   update_taken                 resolved direction (1 = taken)
//   update_predicted             prediction carried with the branch (stats only)
//   stat_branches[31:0]          resolved-branch count (BTB_STATS_EN)
//   stat_mispredicts[31:0]       mispredict count (BTB_STATS_EN)
//
// Handshake: update_valid is a single-cycle valid with no ready; the table
//   always accepts an update on the edge where update_valid is high and
//   reset_n is high. Lookup has no handshake at all.
module branch_target_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] lookup_pc,
  output logic        branch_prediction_actual,
  output logic [31:0] pc_target_prediction_actual,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_predicted
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Address split: [1:0] byte offset (ignored), then index, then tag.
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_W-1:0]      lookup_tag;
  logic [INDEX_BITS-1:0] update_idx;
  logic [TAG_W-1:0]      update_tag;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign lookup_tag = lookup_pc[31:INDEX_BITS+2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  assign update_tag = update_pc[31:INDEX_BITS+2];

  // Byte-offset bits are deliberately ignored; update_predicted only feeds
  // the optional statistics.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_predicted};

  // ---------------- lookup (combinational, pre-update state) -------------
  logic lookup_hit;

  always_comb begin
    lookup_hit                  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    branch_prediction_actual    = lookup_hit && ctr_q[lookup_idx][1];
    pc_target_prediction_actual = 32'd0;
    if (branch_prediction_actual) begin
      pc_target_prediction_actual = target_q[lookup_idx];
    end
  end

  // ---------------- training --------------------------------------------
  logic update_hit;
  assign update_hit = valid_q[update_idx] && (tag_q[update_idx] == update_tag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update_valid) begin
      if (update_hit) begin
        if (update_taken) begin
          if (ctr_q[update_idx] != 2'b11) begin
            ctr_q[update_idx] <= ctr_q[update_idx] + 2'b01;
          end
          target_q[update_idx] <= update_target;
        end else if (ctr_q[update_idx] != 2'b00) begin
          ctr_q[update_idx] <= ctr_q[update_idx] - 2'b01;
        end
      end else if (update_taken) begin
        // Allocation replaces whatever aliases at this index, starting weak taken.
        valid_q[update_idx]  <= 1'b1;
        tag_q[update_idx]    <= update_tag;
        target_q[update_idx] <= update_target;
        ctr_q[update_idx]    <= 2'b10;
      end
      // Miss and not taken: nothing worth remembering.
    end
  end

`ifdef BTB_STATS_EN
  // ---------------- statistics (saturating) -----------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else if (update_valid) begin
      if (stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if ((update_predicted != update_taken) && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
//   Table-driven bench for branch_target_predictor. Each record drives one
//   cycle of update/lookup; the expected lookup result is pushed to exp_q
//   when the cycle is driven and popped when the combinational output is
//   sampled (1 time unit after the falling edge, before the training edge,
//   so each record observes the pre-update table state). Hand-written
//   sequences cover reset behaviour and the statistics counters.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset_n;
  logic [31:0] lookup_pc;
  logic        branch_prediction_actual;
  logic [31:0] pc_target_prediction_actual;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_predicted;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_target_predictor #(.INDEX_BITS(4)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .lookup_pc                   (lookup_pc),
    .branch_prediction_actual    (branch_prediction_actual),
    .pc_target_prediction_actual (pc_target_prediction_actual),
    .update_valid                (update_valid),
    .update_pc                   (update_pc),
    .update_target               (update_target),
    .update_taken                (update_taken),
    .update_predicted            (update_predicted)
`ifdef BTB_STATS_EN
    ,
    .stat_branches               (stat_branches),
    .stat_mispredicts            (stat_mispredicts)
`endif
  );

  // ---------------- clock / reset ----------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard -------------------------------------------
  logic [32:0] exp_q[$];   // {prediction, target}
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic pred, input logic [31:0] tgt);
    exp_q.push_back({pred, tgt});
  endtask

  task automatic pop_check(input string name);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".pred"}, {31'd0, branch_prediction_actual}, {31'd0, e[32]});
      check({name, ".target"}, pc_target_prediction_actual, e[31:0]);
    end
  endtask

  // ---------------- driver -----------------------------------------------
  task automatic drive(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ut, input logic up, input logic [31:0] lpc);
    update_valid     = uv;
    update_pc        = upc;
    update_target    = utgt;
    update_taken     = ut;
    update_predicted = up;
    lookup_pc        = lpc;
  endtask

  // ---------------- vector table -----------------------------------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic [31:0] lpc;
    logic        ep;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                     input logic ut, input logic [31:0] lpc, input logic ep,
                     input logic [31:0] etgt);
    vecs.push_back('{uv, upc, utgt, ut, lpc, ep, etgt});
  endtask

  int model_branches;
  int model_mispredicts;

  initial begin
    logic up;
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h40);
    #1;
    push_exp(1'b0, 32'd0);
    pop_check("in_reset");

    // Expected outputs reflect the table state before that row's update.
    //   uv  upc        utgt        ut   lpc        pred  target
    add(0, 32'h0,     32'h0,      0,   32'h40,    0,    32'h0);    // after reset
    add(1, 32'h40,    32'h100,    1,   32'h40,    0,    32'h0);    // allocate, same-cycle
    add(0, 32'h0,     32'h0,      0,   32'h40,    1,    32'h100);  // ctr 10
    add(1, 32'h40,    32'h0,      0,   32'h40,    1,    32'h100);  // -> 01
    add(0, 32'h0,     32'h0,      0,   32'h40,    0,    32'h0);
    add(1, 32'h40,    32'h0,      0,   32'h40,    0,    32'h0);    // -> 00
    add(1, 32'h40,    32'h0,      0,   32'h40,    0,    32'h0);    // stays 00
    add(1, 32'h40,    32'h100,    1,   32'h40,    0,    32'h0);    // -> 01
    add(0, 32'h0,     32'h0,      0,   32'h40,    0,    32'h0);    // still not taken
    add(1, 32'h40,    32'h100,    1,   32'h40,    0,    32'h0);    // -> 10
    add(0, 32'h0,     32'h0,      0,   32'h40,    1,    32'h100);
    add(1, 32'h40,    32'h140,    1,   32'h40,    1,    32'h100);  // -> 11, new target
    add(1, 32'h40,    32'h140,    1,   32'h40,    1,    32'h140);  // saturate 11
    add(1, 32'h40,    32'hDEAD0,  0,   32'h40,    1,    32'h140);  // -> 10, target kept
    add(1, 32'h40,    32'hDEAD0,  0,   32'h40,    1,    32'h140);  // -> 01
    add(0, 32'h0,     32'h0,      0,   32'h40,    0,    32'h0);
    add(1, 32'h80,    32'h200,    1,   32'h80,    0,    32'h0);    // alias allocate
    add(0, 32'h0,     32'h0,      0,   32'h40,    0,    32'h0);    // evicted
    add(0, 32'h0,     32'h0,      0,   32'h80,    1,    32'h200);
    add(1, 32'hC0,    32'h999,    0,   32'h83,    1,    32'h200);  // NT miss, low bits ignored
    add(0, 32'h0,     32'h0,      0,   32'h80,    1,    32'h200);  // index 0 unchanged
    add(0, 32'h80,    32'h0,      0,   32'h80,    1,    32'h200);  // invalid update ignored
    add(0, 32'h80,    32'h0,      0,   32'h80,    1,    32'h200);
    add(1, 32'h44,    32'h300,    1,   32'h44,    0,    32'h0);    // index 1
    add(0, 32'h0,     32'h0,      0,   32'h46,    1,    32'h300);
    add(0, 32'h0,     32'h0,      0,   32'h80,    1,    32'h200);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_branches    = 0;
    model_mispredicts = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      up = 1'($urandom_range(0, 1));
      drive(vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].ut, up, vecs[i].lpc);
      push_exp(vecs[i].ep, vecs[i].etgt);
      if (vecs[i].uv) begin
        model_branches++;
        if (up != vecs[i].ut) model_mispredicts++;
      end
      #1;
      pop_check($sformatf("vec%0d", i));
    end

    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h80);
    #1;
    push_exp(1'b1, 32'h200);
    pop_check("post_table");
`ifdef BTB_STATS_EN
    check("stat_branches_table", stat_branches, 32'(model_branches));
    check("stat_mispredicts_table", stat_mispredicts, 32'(model_mispredicts));
`endif

    // Reset asserted between edges with an update pending: clears at once,
    // and the pending update is discarded.
    #2;
    drive(1'b1, 32'h44, 32'h500, 1'b1, 1'b1, 32'h80);
    reset_n = 1'b0;
    #1;
    push_exp(1'b0, 32'd0);
    pop_check("async_reset");
`ifdef BTB_STATS_EN
    check("stat_branches_async", stat_branches, 32'd0);
    check("stat_mispredicts_async", stat_mispredicts, 32'd0);
`endif
    @(posedge clk);
    #1;
    lookup_pc = 32'h44;
    #1;
    push_exp(1'b0, 32'd0);
    pop_check("update_during_reset");

    // Release: the first edge with reset_n high accepts the update.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    push_exp(1'b0, 32'd0);
    pop_check("release_pre");
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h44);
    #1;
    push_exp(1'b1, 32'h500);
    pop_check("first_update_after_release");
    lookup_pc = 32'h80;
    #1;
    push_exp(1'b0, 32'd0);
    pop_check("table_cleared");

`ifdef BTB_STATS_EN
    // Counters from a clean reset: (pred, taken) = (0,1), (1,1), (0,0).
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'h48, 32'h600, 1'b1, 1'b0, 32'h48);
    @(negedge clk);
    drive(1'b1, 32'h48, 32'h600, 1'b1, 1'b1, 32'h48);
    @(negedge clk);
    drive(1'b1, 32'h4C, 32'h0,   1'b0, 1'b0, 32'h48);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h48);
    #1;
    check("stat_branches_3", stat_branches, 32'd3);
    check("stat_mispredicts_1", stat_mispredicts, 32'd1);
    push_exp(1'b1, 32'h600);
    pop_check("stats_lookup");
    #2;
    reset_n = 1'b0;
    #1;
    check("stat_branches_pulse", stat_branches, 32'd0);
    check("stat_mispredicts_pulse", stat_mispredicts, 32'd0);
    push_exp(1'b0, 32'd0);
    pop_check("pulse_lookup");
    #1;
    reset_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
